bin_to_ex3_seq: RTL

- Parametrised, multi-digit, sequential binary-to-decimal converter; successor to the 4-bit combinational binary-to-excess-3 converter.
- Converts a BIN_W-bit unsigned value to DIGITS decimal digits using iterative shift-and-add-3 (double dabble), one bit per clock.
- Output is selectable per conversion: packed BCD, or excess-3 (each digit +3).
- Sits between datapath counters and display/decimal encoders; start/busy/done handshake.

---
 rtl/bin_to_ex3_seq.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/bin_to_ex3_seq.sv
// Sequential binary-to-decimal converter (double dabble, one bit per clock)
// with a per-conversion choice of packed BCD or excess-3 output digits.
module bin_to_ex3_seq #(
  parameter int BIN_W  = 8,
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [BIN_W-1:0]      bin_in,
  input  logic                  mode_ex3,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   dec_out,
  output logic                  ovf
);

  localparam int DW = 4 * DIGITS;
  localparam int CW = $clog2(BIN_W + 1);
  localparam logic [CW-1:0] LAST_COUNT = CW'(BIN_W);

  typedef enum logic [1:0] {
    IDLE,
    CONV,
    DONE
  } state_e;

  state_e            state_q, state_d;
  logic [BIN_W-1:0]  shift_q, shift_d;
  logic [DW-1:0]     accum_q, accum_d;
  logic [CW-1:0]     count_q, count_d;
  logic              mode_q, mode_d;
  logic              ovfAcc_q, ovfAcc_d;
  logic [DW-1:0]     decOut_q;
  logic              ovfOut_q;

  logic [DW-1:0]       corrected;
  logic [DW+BIN_W-1:0] joined;
  logic [DW-1:0]       ex3Value;

  // Each BCD digit is corrected independently; no carry crosses a digit boundary.
  function automatic logic [DW-1:0] addThreeIfBig(input logic [DW-1:0] value);
    logic [DW-1:0] result;
    result = value;
    for (int i = 0; i < DIGITS; i++) begin
      if (value[4*i +: 4] >= 4'd5) begin
        result[4*i +: 4] = value[4*i +: 4] + 4'd3;
      end
    end
    return result;
  endfunction

  function automatic logic [DW-1:0] toExcess3(input logic [DW-1:0] value);
    logic [DW-1:0] result;
    for (int i = 0; i < DIGITS; i++) begin
      result[4*i +: 4] = value[4*i +: 4] + 4'd3;
    end
    return result;
  endfunction

  always_comb begin
    corrected = addThreeIfBig(accum_q);
    joined    = {corrected, shift_q} << 1;
    ex3Value  = toExcess3(accum_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = CONV;
      CONV:    if (count_q == LAST_COUNT) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q != IDLE);
    done = (state_q == DONE);
  end

  // The extra CONV cycle with count == BIN_W does no shifting; it hands off to DONE.
  always_comb begin
    shift_d  = shift_q;
    accum_d  = accum_q;
    count_d  = count_q;
    mode_d   = mode_q;
    ovfAcc_d = ovfAcc_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          shift_d  = bin_in;
          accum_d  = '0;
          count_d  = '0;
          mode_d   = mode_ex3;
          ovfAcc_d = 1'b0;
        end
      end
      CONV: begin
        if (count_q != LAST_COUNT) begin
          shift_d  = joined[BIN_W-1:0];
          accum_d  = joined[DW+BIN_W-1:BIN_W];
          ovfAcc_d = ovfAcc_q | corrected[DW-1];
          count_d  = count_q + 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift_q  <= '0;
      accum_q  <= '0;
      count_q  <= '0;
      mode_q   <= 1'b0;
      ovfAcc_q <= 1'b0;
    end else begin
      shift_q  <= shift_d;
      accum_q  <= accum_d;
      count_q  <= count_d;
      mode_q   <= mode_d;
      ovfAcc_q <= ovfAcc_d;
    end
  end

  // Results hold through IDLE and CONV and only change on the DONE entry edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      decOut_q <= '0;
      ovfOut_q <= 1'b0;
    end else if (state_q == CONV && state_d == DONE) begin
      decOut_q <= mode_q ? ex3Value : accum_q;
      ovfOut_q <= ovfAcc_q;
    end
  end

  assign dec_out = decOut_q;
  assign ovf     = ovfOut_q;

endmodule
